// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Multiplexed N-digit seven-segment display driver. A binary value captured
// on a load strobe is shown either directly in hex or, in decimal mode, after
// a sequential double-dabble conversion (one shift per clock). The finished
// value is held in a shadow register that is only written on completion, and
// the digits are scanned one at a time with a programmable dwell.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active low
//   bin_in     in   [BIN_W-1:0] binary value to display
//   load       in   one-cycle strobe; samples bin_in and dec_mode
//   dec_mode   in   1 = decimal (BCD conversion), 0 = hex
//   lz_blank   in   1 = blank leading zeros (live, not latched)
//   busy       out  conversion in progress; load ignored while high
//   ovf        out  displayed value did not fit in DIGITS digits
//   seg        out  [6:0] segments {a..g}, bit6 = a, active low
//   digit_sel  out  [DIGITS-1:0] active-low one-hot digit enable, bit0 = LSD
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  input  logic              dec_mode,
  input  logic              lz_blank,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0001100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      4'hF:    s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_e              state_q;
  logic [BIN_W-1:0]    shift_q;
  logic [SW-1:0]       bcd_q;
  logic                conv_ovf_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       shadow_q;
  logic                ovf_q;
  logic                busy_q;
  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;

  logic [BIN_W+SW-1:0] load_ext_s;
  logic [SW-1:0]       hex_shadow_s;
  logic                hex_ovf_s;
  logic [SW-1:0]       bcd_adj_s;
  logic [SW-1:0]       bcd_d;
  logic [BIN_W-1:0]    shift_d;
  logic                carry_s;
  logic [3:0]          nib_s;
  logic                upper_zero_s;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   sel_d;

  // Hex-mode capture: zero-extend so any input bits above the display width
  // can be tested for overflow with a single shift.
  always_comb begin
    load_ext_s   = {{SW{1'b0}}, bin_in};
    hex_shadow_s = load_ext_s[SW-1:0];
    hex_ovf_s    = |(load_ext_s >> SW);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, shift}
  // left. The bit leaving the top nibble means the value needs more digits.
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        bcd_adj_s[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*d +: 4] = bcd_q[4*d +: 4];
      end
    end
    carry_s = bcd_adj_s[SW-1];
    bcd_d   = {bcd_adj_s[SW-2:0], shift_q[BIN_W-1]};
    shift_d = shift_q << 1;
  end

  // Load / conversion FSM with registered busy, shadow and overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      conv_ovf_q <= 1'b0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            if (dec_mode) begin
              shift_q    <= bin_in;
              bcd_q      <= '0;
              conv_ovf_q <= 1'b0;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= CONV;
            end else begin
              shadow_q <= hex_shadow_s;
              ovf_q    <= hex_ovf_s;
            end
          end
        end
        CONV: begin
          bcd_q      <= bcd_d;
          shift_q    <= shift_d;
          conv_ovf_q <= conv_ovf_q | carry_s;
          cnt_q      <= cnt_q + CW'(1);
          if (cnt_q == CW'(BIN_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          shadow_q <= bcd_q;
          ovf_q    <= conv_ovf_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pattern for the currently indexed digit. "Upper zero" covers this digit
  // and every digit above it, which is what leading-zero blanking needs.
  always_comb begin
    nib_s        = 4'(shadow_q >> {idx_q, 2'b00});
    upper_zero_s = ((shadow_q >> {idx_q, 2'b00}) == '0);
    sel_d        = ~(DIGITS'(1) << idx_q);
    if (ovf_q) begin
      seg_d = 7'b1111110;
    end else if (lz_blank && (idx_q != '0) && upper_zero_s) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_decode(nib_s);
    end
  end

  // Scan prescaler, digit index and the aligned seg/digit_sel registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1111111;
      sel_q   <= '1;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign seg       = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BIN_W-1:0]  bin_in;
  logic              load;
  logic              dec_mode;
  logic              lz_blank;
  logic              busy;
  logic              ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_sel;

  int n_checks = 0;
  int n_errors = 0;

  seven_seg_scan_driver #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin_in   (bin_in),
    .load     (load),
    .dec_mode (dec_mode),
    .lz_blank (lz_blank),
    .busy     (busy),
    .ovf      (ovf),
    .seg      (seg),
    .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  // Reference segment table, indexed by digit value.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Behavioural model: displayed digits as integers, a busy countdown and
  // the pending result of a decimal load computed by plain division.
  int         m_dig [DIGITS];
  int         m_pend_dig [DIGITS];
  bit         m_ovf, m_pend_ovf, m_busy;
  int         m_remain, m_idx, m_presc;
  logic [6:0] e_seg;
  logic [3:0] e_sel;

  task automatic model_edge();
    int v;
    bit hz;
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) m_dig[k] = 0;
      m_ovf = 0; m_busy = 0; m_remain = 0; m_idx = 0; m_presc = 0;
      e_seg = 7'b1111111; e_sel = 4'b1111;
    end else begin
      e_sel = ~(4'b0001 << m_idx);
      if (m_ovf) begin
        e_seg = 7'b1111110;
      end else begin
        hz = 1;
        for (int k = m_idx; k < DIGITS; k++) if (m_dig[k] != 0) hz = 0;
        if (lz_blank && m_idx != 0 && hz) e_seg = 7'b1111111;
        else e_seg = seg_tab[m_dig[m_idx]];
      end
      if (m_presc == SCAN_DIV - 1) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % DIGITS;
      end else begin
        m_presc++;
      end
      v = int'(bin_in);
      if (m_busy) begin
        m_remain--;
        if (m_remain == 0) begin
          m_busy = 0;
          m_dig  = m_pend_dig;
          m_ovf  = m_pend_ovf;
        end
      end else if (load) begin
        if (dec_mode) begin
          m_busy     = 1;
          m_remain   = BIN_W + 1;
          m_pend_ovf = (v >= 10 ** DIGITS);
          for (int k = 0; k < DIGITS; k++) m_pend_dig[k] = (v / (10 ** k)) % 10;
        end else begin
          m_ovf = (v >= (1 << (4 * DIGITS)));
          for (int k = 0; k < DIGITS; k++) m_dig[k] = (v >> (4 * k)) & 15;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int sel_index(input logic [3:0] s);
    int k = -1;
    for (int b = 0; b < DIGITS; b++) if (s[b] === 1'b0) k = b;
    return k;
  endfunction

  task automatic test_reset();
    logic [3:0] ws;
    rst_n = 1'b0; load = 1'b1; dec_mode = 1'b1; bin_in = 14'd1234; lz_blank = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {7'b1111111, 4'b1111, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL reset_hold: got seg=%b sel=%b busy=%b ovf=%b, want 1111111 1111 0 0", seg, digit_sel, busy, ovf);
      end
    end
    rst_n = 1'b1; load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      ws = ~(4'b0001 << (c / 2));
      n_checks++;
      if ({seg, digit_sel} !== {7'b0000001, ws}) begin
        n_errors++;
        $display("FAIL first_frame c=%0d: got seg=%b sel=%b, want 0000001 %b", c, seg, digit_sel, ws);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] want [4] = '{7'b0010010, 7'b0111000, 7'b0001000, 7'b0000110};
    int k;
    for (int c = 0; c < 11; c++) begin
      load = (c == 0); dec_mode = 1'b0; bin_in = 14'h3AF2; lz_blank = 1'b0;
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL hex_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
      k = sel_index(digit_sel);
      if (c >= 1) begin
        n_checks++;
        if (k < 0 || seg !== want[k] || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL hex_digit c=%0d: got seg=%b sel=%b busy=%b", c, seg, digit_sel, busy);
        end
      end
    end
  endtask

  task automatic test_decimal();
    logic [6:0] want_a [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    logic [6:0] want_b [4] = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
    int k;
    int busy_cnt = 0;
    for (int c = 0; c < 48; c++) begin
      load = (c == 0 || c == 24); dec_mode = 1'b1;
      bin_in = (c < 24) ? 14'd1234 : 14'd42;
      lz_blank = (c >= 24);
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL dec_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
      if (c <= 23 && busy === 1'b1) busy_cnt++;
      k = sel_index(digit_sel);
      if (c >= 16 && c <= 23) begin
        n_checks++;
        if (k < 0 || seg !== want_a[k]) begin
          n_errors++;
          $display("FAIL dec_1234 c=%0d: got seg=%b sel=%b", c, seg, digit_sel);
        end
      end
      if (c >= 40) begin
        n_checks++;
        if (k < 0 || seg !== want_b[k]) begin
          n_errors++;
          $display("FAIL dec_42_blank c=%0d: got seg=%b sel=%b", c, seg, digit_sel);
        end
      end
    end
    n_checks++;
    if (busy_cnt != 15) begin
      n_errors++;
      $display("FAIL busy_len: got %0d cycles, want 15", busy_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] want [4] = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
    int k;
    for (int c = 0; c < 48; c++) begin
      load = (c == 0 || c == 24); dec_mode = 1'b1;
      bin_in = (c < 24) ? 14'd12000 : 14'd0;
      lz_blank = (c >= 24);
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL ovf_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
      if (c >= 16 && c <= 23) begin
        n_checks++;
        if (ovf !== 1'b1 || seg !== 7'b1111110) begin
          n_errors++;
          $display("FAIL ovf_dash c=%0d: got ovf=%b seg=%b, want 1 1111110", c, ovf, seg);
        end
      end
      k = sel_index(digit_sel);
      if (c >= 40) begin
        n_checks++;
        if (ovf !== 1'b0 || k < 0 || seg !== want[k]) begin
          n_errors++;
          $display("FAIL ovf_clear c=%0d: got ovf=%b seg=%b sel=%b", c, ovf, seg, digit_sel);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] want [4] = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
    int k;
    for (int c = 0; c < 24; c++) begin
      load = (c == 0 || c == 5); dec_mode = 1'b1;
      bin_in = (c == 0) ? 14'd5678 : 14'd1111;
      lz_blank = 1'b0;
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL b2b_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
      if (c <= 15) begin
        n_checks++;
        if (busy !== (c <= 14)) begin
          n_errors++;
          $display("FAIL b2b_busy c=%0d: got %b, want %b", c, busy, (c <= 14));
        end
      end
      k = sel_index(digit_sel);
      if (c >= 16) begin
        n_checks++;
        if (k < 0 || seg !== want[k]) begin
          n_errors++;
          $display("FAIL b2b_5678 c=%0d: got seg=%b sel=%b", c, seg, digit_sel);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 40; c++) begin
      load = (c == 0); dec_mode = 1'b1; bin_in = 14'd9999; lz_blank = 1'b0;
      rst_n = (c != 7);
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL rmid_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
      n_checks++;
      if (seg === 7'b0001100 || (c >= 7 && busy !== 1'b0) || (c >= 8 && seg !== 7'b0000001)) begin
        n_errors++;
        $display("FAIL rmid_abort c=%0d: got seg=%b busy=%b", c, seg, busy);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 5) == 0);
      dec_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) lz_blank = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       bin_in = 14'($urandom_range(0, 99));
        1:       bin_in = 14'($urandom_range(0, 9999));
        default: bin_in = 14'($urandom_range(0, 16383));
      endcase
      tick();
      n_checks++;
      if ({seg, digit_sel, busy, ovf} !== {e_seg, e_sel, m_busy, m_ovf}) begin
        n_errors++;
        $display("FAIL rand_model c=%0d: got %b %b %b %b, want %b %b %b %b", c, seg, digit_sel, busy, ovf, e_seg, e_sel, m_busy, m_ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; dec_mode = 1'b0; lz_blank = 1'b0; bin_in = '0;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
